// File: rtl/twophase_rx_pkg.sv
// twophase_rx_pkg: shared state encodings and default parameters for the two-phase handshake blocks
package twophase_rx_pkg;
    typedef enum logic {
        TP_IDLE = 1'b0,
        TP_HOLD = 1'b1
    } tp_state_t;
    localparam int TP_DEF_WIDTH       = 8;
    localparam int TP_DEF_SYNC_STAGES = 2;
    localparam int TP_DEF_CNT_W       = 8;
endpackage

// File: rtl/twophase_rx_sync_chain.sv
// sync_chain: generic N-flop synchroniser, async reset to 0
//   clk, rst : clock and async active-high reset
//   d        : asynchronous input level
//   q        : synchronised level, STAGES clk edges behind d
module sync_chain #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] r;
    always_ff @(posedge clk or posedge rst)
        if (rst) r <= '0;
        else     r <= {r[STAGES-2:0], d};
    assign q = r[STAGES-1];
endmodule

// File: rtl/twophase_rx.sv
// twophase_rx: two-phase (toggle) handshake receiver turning req_tgl edges into valid/ready transfers
//   clk, rst  : clock and async active-high reset
//   req_tgl   : sender request level, every transition announces one word
//   req_data  : sender data, stable from req_tgl edge to ack_tgl edge
//   out_ready : local consumer accepts out_data
//   out_valid : out_data holds an unconsumed word
//   out_data  : captured word
//   ack_tgl   : acknowledge level, toggles once per completed transfer
//   overrun   : sticky, a req_tgl edge arrived while a word was pending
//   rx_count  : completed transfers modulo 2**CNT_W
module twophase_rx
    import twophase_rx_pkg::*;
#(
    parameter int WIDTH       = TP_DEF_WIDTH,
    parameter int SYNC_STAGES = TP_DEF_SYNC_STAGES,
    parameter int CNT_W       = TP_DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_tgl,
    input  logic [WIDTH-1:0] req_data,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             ack_tgl,
    output logic             overrun,
    output logic [CNT_W-1:0] rx_count
);
    tp_state_t state, state_nx;
    logic req_s, req_seen, ev, hold;

    sync_chain #(.STAGES(SYNC_STAGES)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (req_tgl),
        .q   (req_s)
    );

    // Any difference from the last accepted level is one announced word.
    assign ev   = req_s ^ req_seen;
    assign hold = state == TP_HOLD;

    always_ff @(posedge clk or posedge rst)
        if (rst) state <= TP_IDLE;
        else     state <= state_nx;

    always_comb
        state_nx = hold ? (out_ready ? TP_IDLE : TP_HOLD) : (ev ? TP_HOLD : TP_IDLE);

    always_comb
        out_valid = hold;

    // An edge seen in HOLD is consumed (req_seen follows) but its data is dropped,
    // so it is never re-detected after the pending word drains.
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            req_seen <= 1'b0;
            out_data <= '0;
            ack_tgl  <= 1'b0;
            overrun  <= 1'b0;
            rx_count <= '0;
        end else begin
            if (ev) req_seen <= req_s;
            if (!hold && ev) out_data <= req_data;
            if (hold && ev) overrun <= 1'b1;
            if (hold && out_ready) begin
                ack_tgl  <= ~ack_tgl;
                rx_count <= rx_count + CNT_W'(1);
            end
        end
endmodule

// File: tb/tb_twophase_rx.sv
// tb_twophase_rx: directed self-checking bench for twophase_rx
module tb_twophase_rx;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_tgl = 1'b0;
    logic [7:0] req_data = 8'h00;
    logic       out_ready = 1'b0;
    logic       out_valid;
    logic [7:0] out_data;
    logic       ack_tgl;
    logic       overrun;
    logic [7:0] rx_count;

    int total = 0;
    int bad = 0;
    logic       exp_ack = 1'b0;
    logic [7:0] exp_cnt = 8'h00;

    twophase_rx dut (
        .clk       (clk),
        .rst       (rst),
        .req_tgl   (req_tgl),
        .req_data  (req_data),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .ack_tgl   (ack_tgl),
        .overrun   (overrun),
        .rx_count  (rx_count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic xfer(input logic [7:0] d);
        req_data  = d;
        req_tgl   = ~req_tgl;
        out_ready = 1'b1;
        step();
        step();
        chk("xfer_valid_early", 32'(out_valid), 32'd0);
        step();
        chk("xfer_valid", 32'(out_valid), 32'd1);
        chk("xfer_data", 32'(out_data), 32'(d));
        step();
        exp_ack = ~exp_ack;
        exp_cnt = exp_cnt + 8'd1;
        chk("xfer_valid_drop", 32'(out_valid), 32'd0);
        chk("xfer_ack", 32'(ack_tgl), 32'(exp_ack));
        chk("xfer_count", 32'(rx_count), 32'(exp_cnt));
    endtask

    initial begin
        // 1: reset held, req_tgl wiggling
        for (int i = 0; i < 4; i++) begin
            req_tgl = ~req_tgl;
            step();
            chk("rst_valid", 32'(out_valid), 32'd0);
            chk("rst_ack", 32'(ack_tgl), 32'd0);
            chk("rst_count", 32'(rx_count), 32'd0);
        end
        req_tgl = 1'b0;
        step();
        rst = 1'b0;
        // out_ready in IDLE is ignored
        out_ready = 1'b1;
        repeat (3) step();
        chk("idle_ready_ack", 32'(ack_tgl), 32'd0);
        chk("idle_ready_count", 32'(rx_count), 32'd0);
        chk("idle_ready_valid", 32'(out_valid), 32'd0);
        // 2: rising edge word
        xfer(8'hA5);
        // 3: falling edge word
        xfer(8'h3C);
        // 4: backpressure
        out_ready = 1'b0;
        req_data  = 8'h55;
        req_tgl   = ~req_tgl;
        repeat (3) step();
        chk("bp_valid", 32'(out_valid), 32'd1);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("bp_hold_valid", 32'(out_valid), 32'd1);
            chk("bp_hold_data", 32'(out_data), 32'h55);
            chk("bp_hold_ack", 32'(ack_tgl), 32'(exp_ack));
        end
        out_ready = 1'b1;
        step();
        exp_ack = ~exp_ack;
        exp_cnt = exp_cnt + 8'd1;
        chk("bp_release_valid", 32'(out_valid), 32'd0);
        chk("bp_release_ack", 32'(ack_tgl), 32'(exp_ack));
        chk("bp_release_count", 32'(rx_count), 32'(exp_cnt));
        // 5: overrun
        out_ready = 1'b0;
        req_data  = 8'h11;
        req_tgl   = ~req_tgl;
        repeat (3) step();
        chk("ovr_valid", 32'(out_valid), 32'd1);
        chk("ovr_pre", 32'(overrun), 32'd0);
        req_data = 8'h22;
        req_tgl  = ~req_tgl;
        repeat (3) step();
        chk("ovr_flag", 32'(overrun), 32'd1);
        chk("ovr_data_kept", 32'(out_data), 32'h11);
        out_ready = 1'b1;
        step();
        exp_ack = ~exp_ack;
        exp_cnt = exp_cnt + 8'd1;
        chk("ovr_count", 32'(rx_count), 32'(exp_cnt));
        repeat (5) step();
        chk("ovr_no_redetect_valid", 32'(out_valid), 32'd0);
        chk("ovr_no_redetect_count", 32'(rx_count), 32'(exp_cnt));
        chk("ovr_sticky", 32'(overrun), 32'd1);
        // 6: wrap the counter to zero
        while (exp_cnt != 8'd255) xfer(8'(exp_cnt ^ 8'h5A));
        chk("wrap_pre", 32'(rx_count), 32'd255);
        xfer(8'hFF);
        chk("wrap_zero", 32'(rx_count), 32'd0);
        // reset during HOLD
        out_ready = 1'b0;
        req_data  = 8'h77;
        req_tgl   = ~req_tgl;
        repeat (3) step();
        chk("rst_hold_valid_pre", 32'(out_valid), 32'd1);
        rst = 1'b1;
        req_tgl = 1'b0;
        #1;
        chk("rst_hold_valid", 32'(out_valid), 32'd0);
        chk("rst_hold_overrun", 32'(overrun), 32'd0);
        chk("rst_hold_ack", 32'(ack_tgl), 32'd0);
        chk("rst_hold_data", 32'(out_data), 32'd0);
        step();
        rst = 1'b0;
        exp_ack = 1'b0;
        exp_cnt = 8'h00;
        xfer(8'hC3);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
